// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for the 5-stage MIPS pipeline.
// Generates write-enable and clear strobes for the PC, IF/ID and ID/EX
// registers. Handles load-use stalls, jump flushes, run/single-step control
// from the debug unit, and a HALT drain followed by a freeze.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run_mode,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_halt_id,
  input  logic             i_jump_taken,
  input  logic             i_id_ex_mem_read,
  input  logic [4:0]       i_id_ex_rt,
  input  logic [4:0]       i_if_id_rs,
  input  logic [4:0]       i_if_id_rt,
  output logic             o_pc_enable,
  output logic             o_if_id_enable,
  output logic             o_if_id_flush,
  output logic             o_id_ex_enable,
  output logic             o_id_ex_flush,
  output logic             o_halted,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_DRAIN  = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  // A zero drain length still needs one advance to push HALT out of ID.
  localparam int DRAIN_LOAD = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
  localparam int DRAIN_W    = $clog2(DRAIN_LOAD + 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_next_drain_cnt;
  logic [CNT_W-1:0]   r_cycle_count;
  logic               w_adv;
  logic               w_hazard;

  // Load-use hazard: the load in EX writes a register the IF/ID instruction reads.
  assign w_hazard = i_id_ex_mem_read && (i_id_ex_rt != 5'd0) &&
                    ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

  // Registered state, drain counter and advance-cycle counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_drain_cnt   <= '0;
      r_cycle_count <= '0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_drain_cnt;
      if (w_adv) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
    end
  end

  // Advance decision, next state and the per-register enable/flush strobes.
  always_comb begin
    w_next_state     = r_state;
    w_next_drain_cnt = r_drain_cnt;
    w_adv            = 1'b0;
    o_pc_enable      = 1'b0;
    o_if_id_enable   = 1'b0;
    o_if_id_flush    = 1'b0;
    o_id_ex_enable   = 1'b0;
    o_id_ex_flush    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_run_mode && i_start) begin
          w_next_state = S_RUN;
        end else if (!i_run_mode && i_step) begin
          w_adv = 1'b1;
        end
      end
      S_RUN: begin
        if (i_run_mode) begin
          w_adv = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (i_run_mode || i_step) begin
          w_adv = 1'b1;
        end
      end
      default: begin
        w_adv = 1'b0;
      end
    endcase

    // Reset overrides everything, so no strobe may leak out during it.
    if (i_reset) begin
      w_adv = 1'b0;
    end

    if (w_adv) begin
      if (r_state == S_DRAIN) begin
        // Keep bubbling both front registers while older instructions retire.
        o_if_id_enable = 1'b1;
        o_if_id_flush  = 1'b1;
        o_id_ex_enable = 1'b1;
        o_id_ex_flush  = 1'b1;
        if (r_drain_cnt <= DRAIN_W'(1)) begin
          w_next_state = S_HALTED;
        end else begin
          w_next_drain_cnt = r_drain_cnt - DRAIN_W'(1);
        end
      end else if (w_hazard) begin
        // Hold PC and IF/ID, insert a bubble into EX; jump/HALT retried next cycle.
        o_id_ex_enable = 1'b1;
        o_id_ex_flush  = 1'b1;
      end else if (i_halt_id) begin
        o_if_id_enable   = 1'b1;
        o_if_id_flush    = 1'b1;
        o_id_ex_enable   = 1'b1;
        w_next_state     = S_DRAIN;
        w_next_drain_cnt = DRAIN_W'(DRAIN_LOAD);
      end else if (i_jump_taken) begin
        o_pc_enable    = 1'b1;
        o_if_id_enable = 1'b1;
        o_if_id_flush  = 1'b1;
        o_id_ex_enable = 1'b1;
      end else begin
        o_pc_enable    = 1'b1;
        o_if_id_enable = 1'b1;
        o_id_ex_enable = 1'b1;
      end
    end
  end

  assign o_halted      = (r_state == S_HALTED);
  assign o_state       = r_state;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl. Each cycle's stimulus
// carries its expected strobes and state; the bench tracks the expected cycle
// count itself and compares everything after outputs settle.
module tb_pipeline_ctrl;

  localparam int CNT_W = 32;

  // Strobe vector order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush}
  localparam logic [4:0] OFF = 5'b00000;
  localparam logic [4:0] NRM = 5'b11010;
  localparam logic [4:0] JMP = 5'b11110;
  localparam logic [4:0] HAZ = 5'b00011;
  localparam logic [4:0] HLT = 5'b01110;
  localparam logic [4:0] DRN = 5'b01111;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_run_mode = 1'b0;
  logic             i_start = 1'b0;
  logic             i_step = 1'b0;
  logic             i_halt_id = 1'b0;
  logic             i_jump_taken = 1'b0;
  logic             i_id_ex_mem_read = 1'b0;
  logic [4:0]       i_id_ex_rt = '0;
  logic [4:0]       i_if_id_rs = '0;
  logic [4:0]       i_if_id_rt = '0;
  logic             o_pc_enable;
  logic             o_if_id_enable;
  logic             o_if_id_flush;
  logic             o_id_ex_enable;
  logic             o_id_ex_flush;
  logic             o_halted;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_cycle_count;

  pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_run_mode       (i_run_mode),
    .i_start          (i_start),
    .i_step           (i_step),
    .i_halt_id        (i_halt_id),
    .i_jump_taken     (i_jump_taken),
    .i_id_ex_mem_read (i_id_ex_mem_read),
    .i_id_ex_rt       (i_id_ex_rt),
    .i_if_id_rs       (i_if_id_rs),
    .i_if_id_rt       (i_if_id_rt),
    .o_pc_enable      (o_pc_enable),
    .o_if_id_enable   (o_if_id_enable),
    .o_if_id_flush    (o_if_id_flush),
    .o_id_ex_enable   (o_id_ex_enable),
    .o_id_ex_flush    (o_id_ex_flush),
    .o_halted         (o_halted),
    .o_state          (o_state),
    .o_cycle_count    (o_cycle_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [4:0]  ctrl;
    logic [1:0]  st;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_count = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus plus its expectation; adv cycles are those with id_ex_en set.
  task automatic cyc(input string tag, input logic rst, input logic run, input logic start,
                     input logic step, input logic halt, input logic jump, input logic mr,
                     input logic [4:0] ex_rt, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] ectrl, input logic [1:0] est);
    exp_t e;
    @(posedge i_clk);
    #1;
    i_reset          = rst;
    i_run_mode       = run;
    i_start          = start;
    i_step           = step;
    i_halt_id        = halt;
    i_jump_taken     = jump;
    i_id_ex_mem_read = mr;
    i_id_ex_rt       = ex_rt;
    i_if_id_rs       = rs;
    i_if_id_rt       = rt;
    e.tag    = tag;
    e.ctrl   = ectrl;
    e.st     = est;
    e.halted = (est == 2'b11);
    e.cnt    = exp_count;
    exp_q.push_back(e);
    if (rst) exp_count = '0;
    else if (ectrl[1]) exp_count = exp_count + 32'd1;
    @(negedge i_clk);
    if (exp_q.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".ctrl"}, {27'd0, o_pc_enable, o_if_id_enable, o_if_id_flush,
                             o_id_ex_enable, o_id_ex_flush}, {27'd0, e.ctrl});
      chk({e.tag, ".state"}, {30'd0, o_state}, {30'd0, e.st});
      chk({e.tag, ".halted"}, {31'd0, o_halted}, {31'd0, e.halted});
      chk({e.tag, ".count"}, o_cycle_count, e.cnt);
    end
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    //  tag        rst run st stp hlt jmp mr ex_rt  rs     rt     ctrl st
    cyc("reset",    1, 0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b00);
    cyc("idle",     0, 1, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b00);
    cyc("start",    0, 1, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b00);
    for (int i = 0; i < 10; i++)
      cyc("run",    0, 1, 0, 0, 0, 0, 0, 5'd0,  5'd3,  5'd4,  NRM, 2'b01);
    cyc("haz_rs",   0, 1, 0, 0, 0, 0, 1, 5'd5,  5'd5,  5'd1,  HAZ, 2'b01);
    cyc("haz_rt",   0, 1, 0, 0, 0, 0, 1, 5'd7,  5'd2,  5'd7,  HAZ, 2'b01);
    cyc("rt_zero",  0, 1, 0, 0, 0, 0, 1, 5'd0,  5'd0,  5'd0,  NRM, 2'b01);
    cyc("no_match", 0, 1, 0, 0, 0, 0, 1, 5'd9,  5'd8,  5'd10, NRM, 2'b01);
    cyc("mr_low",   0, 1, 0, 0, 0, 0, 0, 5'd5,  5'd5,  5'd5,  NRM, 2'b01);
    cyc("haz_jmp",  0, 1, 0, 0, 0, 1, 1, 5'd5,  5'd5,  5'd0,  HAZ, 2'b01);
    cyc("jmp",      0, 1, 0, 0, 0, 1, 0, 5'd5,  5'd5,  5'd0,  JMP, 2'b01);
    cyc("haz_hlt",  0, 1, 0, 0, 1, 0, 1, 5'd6,  5'd0,  5'd6,  HAZ, 2'b01);
    cyc("run_drop", 0, 0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b01);
    cyc("back_idle",0, 0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b00);
    cyc("restart",  0, 1, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b00);
    cyc("step_run", 0, 1, 0, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  NRM, 2'b01);
    cyc("halt",     0, 1, 0, 0, 1, 1, 0, 5'd0,  5'd0,  5'd0,  HLT, 2'b01);
    for (int i = 0; i < 3; i++)
      cyc("drain",  0, 1, 1, 0, 1, 1, 1, 5'd5,  5'd5,  5'd5,  DRN, 2'b10);
    for (int i = 0; i < 4; i++)
      cyc("halted", 0, 1, 1, 1, 0, 1, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b11);
    cyc("rst_halt", 1, 1, 1, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b11);
    cyc("post_rst", 0, 0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b00);
    for (int i = 0; i < 4; i++) begin
      cyc("step",   0, 0, 0, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  NRM, 2'b00);
      cyc("gap",    0, 0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b00);
      cyc("gap2",   0, 0, 1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b00);
    end
    cyc("step_hlt", 0, 0, 0, 1, 1, 0, 0, 5'd0,  5'd0,  5'd0,  HLT, 2'b00);
    cyc("drn_gap",  0, 0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b10);
    cyc("drn_step", 0, 0, 0, 1, 0, 1, 0, 5'd0,  5'd0,  5'd0,  DRN, 2'b10);
    cyc("rst_drain",1, 0, 0, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b10);
    cyc("after_rst",0, 0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b00);
    cyc("step_jmp", 0, 0, 0, 1, 0, 1, 0, 5'd0,  5'd0,  5'd0,  JMP, 2'b00);
    cyc("final",    0, 0, 0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  OFF, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
